alarm_ctrl_multi: RTL and testbench



---
 rtl/alarm_ctrl_multi.sv | 147 ++++++++++++++
 tb/tb_alarm_ctrl_multi.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alarm_ctrl_multi.sv
// alarm_ctrl_multi: N-channel debounced alarm FSM with escalation, acknowledge/re-alarm and sticky history
module alarm_ctrl_multi #(
    parameter int N_SENS       = 4,
    parameter int DEB_CYCLES   = 16,
    parameter int ESC_CYCLES   = 1000,
    parameter int ALARM_MIN    = 2,
    parameter int BLINK_CYCLES = 50,
    localparam int CH_W        = $clog2(N_SENS)
) (
    input  logic              CLK_clk_i,
    input  logic              RST_rst_i,
    input  logic [N_SENS-1:0] Sensor_i,
    input  logic [N_SENS-1:0] Mask_i,
    input  logic              Ack_i,
    output logic [1:0]        estado_o,
    output logic [N_SENS-1:0] activos_o,
    output logic [N_SENS-1:0] latched_o,
    output logic [CH_W-1:0]   canal_o,
    output logic              Buzzer_o,
    output logic [2:0]        Led_o
);
    typedef enum logic [1:0] {NORMAL, PREALERTA, ALARMA, RECONOCIDA} state_t;
    localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    localparam int EW = ESC_CYCLES > 1 ? $clog2(ESC_CYCLES) : 1;
    localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
    localparam int CW = $clog2(N_SENS + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [EW-1:0] ESC_MAX = EW'(ESC_CYCLES - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_CYCLES - 1);
    localparam logic [CW-1:0] AMIN    = CW'(ALARM_MIN);

    state_t            state, nxt;
    logic [N_SENS-1:0] sen_s1, sen_s2, act, snap, snap_nxt, lat_nxt;
    logic              ack_s1, ack_s2, ack_d, ack_rise, led2, buz_nxt;
    logic [DW-1:0]     deb_cnt [N_SENS];
    logic [EW-1:0]     esc_tmr, esc_nxt;
    logic [BW-1:0]     blk_cnt, blk_nxt;
    logic [CW-1:0]     cnt;
    logic [CH_W-1:0]   can_nxt;
    logic [2:0]        led_nxt;

    assign act      = activos_o & ~Mask_i;
    assign ack_rise = ack_s2 & ~ack_d;
    assign estado_o = state;

    always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
        if (!RST_rst_i) begin
            sen_s1    <= '0;
            sen_s2    <= '0;
            ack_s1    <= 1'b0;
            ack_s2    <= 1'b0;
            ack_d     <= 1'b0;
            activos_o <= '0;
            for (int i = 0; i < N_SENS; i++) deb_cnt[i] <= '0;
        end else begin
            sen_s1 <= Sensor_i;
            sen_s2 <= sen_s1;
            ack_s1 <= Ack_i;
            ack_s2 <= ack_s1;
            ack_d  <= ack_s2;
            for (int i = 0; i < N_SENS; i++) begin
                if (sen_s2[i] == activos_o[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    activos_o[i] <= ~activos_o[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt     = '0;
        can_nxt = '0;
        for (int i = 0; i < N_SENS; i++) cnt = cnt + CW'(act[i]);
        for (int i = N_SENS - 1; i >= 0; i--) if (latched_o[i]) can_nxt = CH_W'(i);
    end

    always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
        if (!RST_rst_i) begin
            state     <= NORMAL;
            esc_tmr   <= '0;
            snap      <= '0;
            blk_cnt   <= '0;
            latched_o <= '0;
            canal_o   <= '0;
            Buzzer_o  <= 1'b0;
            Led_o     <= 3'b001;
        end else begin
            state     <= nxt;
            esc_tmr   <= esc_nxt;
            snap      <= snap_nxt;
            blk_cnt   <= blk_nxt;
            latched_o <= lat_nxt;
            canal_o   <= can_nxt;
            Buzzer_o  <= buz_nxt;
            Led_o     <= led_nxt;
        end
    end

    always_comb begin
        nxt      = state;
        esc_nxt  = esc_tmr;
        snap_nxt = snap;
        case (state)
            NORMAL: begin
                if (cnt >= AMIN) nxt = ALARMA;
                else if (cnt != '0) begin
                    nxt     = PREALERTA;
                    esc_nxt = '0;
                end
            end
            PREALERTA: begin
                if (cnt >= AMIN) nxt = ALARMA;
                else if (cnt == '0) nxt = NORMAL;
                else if (esc_tmr == ESC_MAX) nxt = ALARMA;
                else esc_nxt = esc_tmr + 1'b1;
            end
            ALARMA: begin
                if (ack_rise) begin
                    nxt      = RECONOCIDA;
                    snap_nxt = act;
                end
            end
            RECONOCIDA: begin
                if ((act & ~snap) != '0) nxt = ALARMA;
                else if (cnt == '0) nxt = NORMAL;
            end
        endcase
    end

    // clearing wins over the sticky set when both happen on one edge
    always_comb begin
        lat_nxt = ((state == NORMAL && ack_rise) || (state == RECONOCIDA && nxt == NORMAL)) ? '0 :
                  (state != NORMAL) ? (latched_o | act) : latched_o;
        blk_nxt = '0;
        led2    = (nxt == ALARMA);
        if (nxt == RECONOCIDA) begin
            led2    = (state != RECONOCIDA) ? 1'b1 : (blk_cnt == BLK_MAX) ? ~Led_o[2] : Led_o[2];
            blk_nxt = (state != RECONOCIDA || blk_cnt == BLK_MAX) ? '0 : blk_cnt + 1'b1;
        end
        buz_nxt = (nxt == ALARMA);
        led_nxt = {led2, nxt == PREALERTA, nxt == NORMAL};
    end
endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// tb_alarm_ctrl_multi: table-driven directed checks of alarm_ctrl_multi plus async reset sequences
module tb_alarm_ctrl_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] sens = '0, mask = '0;
    logic       ack = 1'b0;
    logic [1:0] estado, canal;
    logic [3:0] activos, latched;
    logic       buzzer;
    logic [2:0] led;
    int         n_chk = 0, n_pass = 0;

    typedef struct {
        logic [3:0] sens, mask;
        logic       ack;
        int         k;
        logic [1:0] est;
        logic [3:0] act, lat;
        logic [1:0] can;
        logic       buz;
        logic [2:0] led;
    } vec_t;
    vec_t vq[$];

    alarm_ctrl_multi #(
        .N_SENS(4), .DEB_CYCLES(4), .ESC_CYCLES(20), .ALARM_MIN(2), .BLINK_CYCLES(8)
    ) dut (
        .CLK_clk_i(clk), .RST_rst_i(rst_n), .Sensor_i(sens), .Mask_i(mask), .Ack_i(ack),
        .estado_o(estado), .activos_o(activos), .latched_o(latched), .canal_o(canal),
        .Buzzer_o(buzzer), .Led_o(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic add(input logic [3:0] s, input logic [3:0] m, input logic a, input int k,
                       input logic [1:0] est, input logic [3:0] ac, input logic [3:0] la,
                       input logic [1:0] ca, input logic bz, input logic [2:0] ld);
        vq.push_back('{s, m, a, k, est, ac, la, ca, bz, ld});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_est"}, 32'(estado), 0);
        chk({tag, "_act"}, 32'(activos), 0);
        chk({tag, "_lat"}, 32'(latched), 0);
        chk({tag, "_can"}, 32'(canal), 0);
        chk({tag, "_buz"}, 32'(buzzer), 0);
        chk({tag, "_led"}, 32'(led), 32'b001);
    endtask

    initial begin
        // baseline and single channel escalation by timeout
        add(4'b0000, 4'b0000, 0,  2, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b0010, 4'b0000, 0,  5, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b0010, 4'b0000, 0,  1, 2'd0, 4'b0010, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b0010, 4'b0000, 0,  1, 2'd1, 4'b0010, 4'b0000, 2'd0, 0, 3'b010);
        add(4'b0010, 4'b0000, 0,  1, 2'd1, 4'b0010, 4'b0010, 2'd0, 0, 3'b010);
        add(4'b0010, 4'b0000, 0, 18, 2'd1, 4'b0010, 4'b0010, 2'd1, 0, 3'b010);
        add(4'b0010, 4'b0000, 0,  1, 2'd2, 4'b0010, 4'b0010, 2'd1, 1, 3'b100);
        add(4'b0010, 4'b0000, 1,  2, 2'd2, 4'b0010, 4'b0010, 2'd1, 1, 3'b100);
        add(4'b0010, 4'b0000, 1,  1, 2'd3, 4'b0010, 4'b0010, 2'd1, 0, 3'b100);
        add(4'b0000, 4'b0000, 0,  6, 2'd3, 4'b0000, 4'b0010, 2'd1, 0, 3'b100);
        add(4'b0000, 4'b0000, 0,  1, 2'd0, 4'b0000, 4'b0000, 2'd1, 0, 3'b001);
        add(4'b0000, 4'b0000, 0,  1, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 3'b001);
        // 3-cycle glitch is rejected
        add(4'b0100, 4'b0000, 0,  3, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b0000, 4'b0000, 0,  8, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 3'b001);
        // two channels go straight to ALARMA, then ack, blink and re-alarm
        add(4'b1001, 4'b0000, 0,  6, 2'd0, 4'b1001, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b1001, 4'b0000, 0,  1, 2'd2, 4'b1001, 4'b0000, 2'd0, 1, 3'b100);
        add(4'b1001, 4'b0000, 0,  1, 2'd2, 4'b1001, 4'b1001, 2'd0, 1, 3'b100);
        add(4'b1001, 4'b0000, 0,  1, 2'd2, 4'b1001, 4'b1001, 2'd0, 1, 3'b100);
        add(4'b1001, 4'b0000, 1,  2, 2'd2, 4'b1001, 4'b1001, 2'd0, 1, 3'b100);
        add(4'b1001, 4'b0000, 1,  1, 2'd3, 4'b1001, 4'b1001, 2'd0, 0, 3'b100);
        add(4'b1001, 4'b0000, 0,  7, 2'd3, 4'b1001, 4'b1001, 2'd0, 0, 3'b100);
        add(4'b1001, 4'b0000, 0,  1, 2'd3, 4'b1001, 4'b1001, 2'd0, 0, 3'b000);
        add(4'b1001, 4'b0000, 0,  8, 2'd3, 4'b1001, 4'b1001, 2'd0, 0, 3'b100);
        add(4'b1101, 4'b0000, 0,  6, 2'd3, 4'b1101, 4'b1001, 2'd0, 0, 3'b100);
        add(4'b1101, 4'b0000, 0,  1, 2'd2, 4'b1101, 4'b1101, 2'd0, 1, 3'b100);
        // ack again, then clear everything from RECONOCIDA; masked channel stays quiet
        add(4'b1101, 4'b0000, 1,  2, 2'd2, 4'b1101, 4'b1101, 2'd0, 1, 3'b100);
        add(4'b1101, 4'b0000, 1,  1, 2'd3, 4'b1101, 4'b1101, 2'd0, 0, 3'b100);
        add(4'b0000, 4'b0000, 0,  6, 2'd3, 4'b0000, 4'b1101, 2'd0, 0, 3'b100);
        add(4'b0000, 4'b0000, 0,  1, 2'd0, 4'b0000, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b0010, 4'b0010, 0,  6, 2'd0, 4'b0010, 4'b0000, 2'd0, 0, 3'b001);
        add(4'b0010, 4'b0010, 0,  2, 2'd0, 4'b0010, 4'b0000, 2'd0, 0, 3'b001);

        #1 rst_n = 1'b0;
        #1 chk_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            sens = vq[i].sens;
            mask = vq[i].mask;
            ack  = vq[i].ack;
            repeat (vq[i].k) @(negedge clk);
            chk($sformatf("v%0d_est", i), 32'(estado),  32'(vq[i].est));
            chk($sformatf("v%0d_act", i), 32'(activos), 32'(vq[i].act));
            chk($sformatf("v%0d_lat", i), 32'(latched), 32'(vq[i].lat));
            chk($sformatf("v%0d_can", i), 32'(canal),   32'(vq[i].can));
            chk($sformatf("v%0d_buz", i), 32'(buzzer),  32'(vq[i].buz));
            chk($sformatf("v%0d_led", i), 32'(led),     32'(vq[i].led));
        end

        // reach ALARMA again, then reset between clock edges
        mask = 4'b0000;
        sens = 4'b1010;
        repeat (8) @(negedge clk);
        chk("s6_est", 32'(estado), 2);
        chk("s6_buz", 32'(buzzer), 1);
        chk("s6_lat", 32'(latched), 32'b1010);
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        repeat (2) @(negedge clk);
        chk_reset("held");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_est", 32'(estado), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
